// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;

   // ceil(width * log10(2)), using log10(2) ~= 0.30103 in fixed point
   function automatic int bcd_digits_for(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit cell: a digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] value,
   output logic [BCD_DIGIT_W-1:0] result
);

   always_comb begin
      result = value;
      if (value >= BCD_DIGIT_W'(5)) begin
         result = value + BCD_DIGIT_W'(3);
      end
   end

endmodule

// File: rtl/seq_bin2bcd.sv
// Multi-cycle shift-and-add-3 converter: one adjust cell per digit, WIDTH shift cycles.
module seq_bin2bcd
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [WIDTH-1:0]            binary,
   output logic                        busy,
   output logic                        done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                        ovf
);

   localparam int ACC_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   if (WIDTH < 2 || DIGITS < 1) begin : g_param_check
      $fatal(1, "seq_bin2bcd: WIDTH must be >= 2 and DIGITS >= 1");
   end

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   shift_reg, shift_next;
   logic [ACC_W-1:0]   acc_reg, acc_next, acc_adj;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               sticky_reg, sticky_next;
   logic [ACC_W-1:0]   bcd_reg, bcd_next;
   logic               ovf_reg, ovf_next;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
         .value  (acc_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .result (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      state_next  = state_reg;
      shift_next  = shift_reg;
      acc_next    = acc_reg;
      count_next  = count_reg;
      sticky_next = sticky_reg;
      bcd_next    = bcd_reg;
      ovf_next    = ovf_reg;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next  = SHIFT;
               shift_next  = binary;
               acc_next    = '0;
               sticky_next = 1'b0;
               count_next  = CNT_W'(WIDTH);
            end else begin
               state_next = IDLE;
            end
         end
         SHIFT: begin
            // The bit pushed out of the top digit is what a wider result would have kept.
            acc_next    = {acc_adj[ACC_W-2:0], shift_reg[WIDTH-1]};
            shift_next  = {shift_reg[WIDTH-2:0], 1'b0};
            sticky_next = sticky_reg | acc_adj[ACC_W-1];
            if (count_reg == CNT_W'(1)) begin
               state_next = DONE;
               bcd_next   = acc_next;
               ovf_next   = sticky_next;
            end else begin
               count_next = count_reg - CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
         sticky_reg <= 1'b0;
         bcd_reg    <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         shift_reg  <= shift_next;
         acc_reg    <= acc_next;
         count_reg  <= count_next;
         sticky_reg <= sticky_next;
         bcd_reg    <= bcd_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign busy = (state_reg == SHIFT);
   assign done = (state_reg == DONE);
   assign bcd  = bcd_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench for seq_bin2bcd in three configurations plus the standalone digit cell.
module tb_seq_bin2bcd;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        a_start, a_busy, a_done, a_ovf;
   logic [7:0]  a_bin;
   logic [11:0] a_bcd;

   logic        b_start, b_busy, b_done, b_ovf;
   logic [15:0] b_bin;
   logic [19:0] b_bcd;

   logic        c_start, c_busy, c_done, c_ovf;
   logic [7:0]  c_bin;
   logic [7:0]  c_bcd;

   logic [3:0]  adj_value, adj_result;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   seq_bin2bcd #(.WIDTH(8), .DIGITS(3)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .binary(a_bin),
      .busy(a_busy), .done(a_done), .bcd(a_bcd), .ovf(a_ovf)
   );

   seq_bin2bcd #(.WIDTH(16), .DIGITS(5)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .binary(b_bin),
      .busy(b_busy), .done(b_done), .bcd(b_bcd), .ovf(b_ovf)
   );

   seq_bin2bcd #(.WIDTH(8), .DIGITS(2)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .binary(c_bin),
      .busy(c_busy), .done(c_done), .bcd(c_bcd), .ovf(c_ovf)
   );

   bcd_digit_adj u_adj (.value(adj_value), .result(adj_result));

   task automatic wait_a(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (a_done) begin seen = 1'b1; break; end
      end
   endtask

   task automatic wait_b(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (b_done) begin seen = 1'b1; break; end
      end
   endtask

   task automatic wait_c(input int limit, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (c_done) begin seen = 1'b1; break; end
      end
   endtask

   function automatic logic [19:0] ref_bcd20(input int unsigned v);
      logic [19:0] r;
      r = '0;
      for (int d = 0; d < 5; d++) begin
         r[d*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      a_start = 0; b_start = 0; c_start = 0;
      a_bin = 0; b_bin = 0; c_bin = 0;
      adj_value = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({a_busy, a_done, a_bcd, a_ovf} !== 15'd0) begin
         errors++; $display("FAIL reset_a: busy=%0b done=%0b bcd=%h ovf=%0b, required all 0", a_busy, a_done, a_bcd, a_ovf);
      end
      checks++;
      if ({b_busy, b_done, b_bcd, b_ovf} !== 23'd0) begin
         errors++; $display("FAIL reset_b: busy=%0b done=%0b bcd=%h ovf=%0b, required all 0", b_busy, b_done, b_bcd, b_ovf);
      end
      checks++;
      if ({c_busy, c_done, c_bcd, c_ovf} !== 11'd0) begin
         errors++; $display("FAIL reset_c: busy=%0b done=%0b bcd=%h ovf=%0b, required all 0", c_busy, c_done, c_bcd, c_ovf);
      end
      rst = 1'b0;
      $display("reset released at cycle %0d", cyc);
   endtask

   task automatic test_digit_adj;
      logic [3:0] exp_tab [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10,
                                   4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
      for (int i = 0; i < 16; i++) begin
         adj_value = 4'(i);
         #1;
         checks++;
         if (adj_result !== exp_tab[i]) begin
            errors++; $display("FAIL digit_adj[%0d]: got %0d, required %0d", i, adj_result, exp_tab[i]);
         end
      end
      $display("digit_adj: 16 inputs swept");
   endtask

   task automatic test_basic;
      @(negedge clk);
      a_start = 1'b1; a_bin = 8'd255;
      @(negedge clk);
      a_start = 1'b0;
      checks++;
      if (a_busy !== 1'b1) begin
         errors++; $display("FAIL basic_busy_e0: busy=%0b, required 1", a_busy);
      end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         checks++;
         if (a_busy !== 1'b1 || a_done !== 1'b0) begin
            errors++; $display("FAIL basic_busy_e%0d: busy=%0b done=%0b, required 1/0", k, a_busy, a_done);
         end
      end
      @(negedge clk);
      checks++;
      if (a_done !== 1'b1 || a_busy !== 1'b0 || a_bcd !== 12'h255 || a_ovf !== 1'b0) begin
         errors++; $display("FAIL basic_result: done=%0b busy=%0b bcd=%h ovf=%0b, required 1/0/255/0", a_done, a_busy, a_bcd, a_ovf);
      end
      @(negedge clk);
      checks++;
      if (a_done !== 1'b0 || a_bcd !== 12'h255) begin
         errors++; $display("FAIL basic_pulse: done=%0b bcd=%h, required 0/255", a_done, a_bcd);
      end
      $display("basic: 255 -> bcd=%h ovf=%0b", a_bcd, a_ovf);
   endtask

   task automatic test_back_to_back;
      bit seen;
      int t1, t2;
      @(negedge clk);
      a_start = 1'b1; a_bin = 8'd0;
      @(negedge clk);
      a_start = 1'b0;
      wait_a(20, seen);
      t1 = cyc;
      checks++;
      if (!seen || a_bcd !== 12'h000 || a_ovf !== 1'b0) begin
         errors++; $display("FAIL b2b_first: seen=%0b bcd=%h ovf=%0b, required 1/000/0", seen, a_bcd, a_ovf);
      end
      a_start = 1'b1; a_bin = 8'd9;
      @(negedge clk);
      a_start = 1'b0;
      wait_a(20, seen);
      t2 = cyc;
      checks++;
      if (!seen || a_bcd !== 12'h009 || a_ovf !== 1'b0) begin
         errors++; $display("FAIL b2b_second: seen=%0b bcd=%h ovf=%0b, required 1/009/0", seen, a_bcd, a_ovf);
      end
      checks++;
      if (t2 - t1 !== 9) begin
         errors++; $display("FAIL b2b_spacing: %0d cycles, required 9", t2 - t1);
      end
      $display("back_to_back: 0 then 9, done spacing %0d", t2 - t1);
   endtask

   task automatic test_ignored_start;
      bit seen;
      int t0;
      @(negedge clk);
      a_start = 1'b1; a_bin = 8'd123;
      t0 = cyc;
      @(negedge clk);
      a_start = 1'b0;
      repeat (2) @(negedge clk);
      a_start = 1'b1; a_bin = 8'd45;
      @(negedge clk);
      a_start = 1'b0; a_bin = 8'd77;
      wait_a(20, seen);
      checks++;
      if (!seen || cyc - t0 !== 9) begin
         errors++; $display("FAIL ignored_start_timing: seen=%0b edges=%0d, required 1/9", seen, cyc - t0);
      end
      checks++;
      if (a_bcd !== 12'h123 || a_ovf !== 1'b0) begin
         errors++; $display("FAIL ignored_start_value: bcd=%h ovf=%0b, required 123/0", a_bcd, a_ovf);
      end
      $display("ignored_start: 123 -> bcd=%h", a_bcd);
   endtask

   task automatic test_reset_abort;
      bit seen;
      bit stray;
      @(negedge clk);
      a_start = 1'b1; a_bin = 8'd200;
      @(negedge clk);
      a_start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({a_busy, a_done, a_bcd, a_ovf} !== 15'd0) begin
         errors++; $display("FAIL abort_async: busy=%0b done=%0b bcd=%h ovf=%0b, required all 0", a_busy, a_done, a_bcd, a_ovf);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stray = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_done || a_busy) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++; $display("FAIL abort_no_done: activity seen after abort, required none");
      end
      @(negedge clk);
      a_start = 1'b1; a_bin = 8'd77;
      @(negedge clk);
      a_start = 1'b0;
      wait_a(20, seen);
      checks++;
      if (!seen || a_bcd !== 12'h077 || a_ovf !== 1'b0) begin
         errors++; $display("FAIL abort_restart: seen=%0b bcd=%h ovf=%0b, required 1/077/0", seen, a_bcd, a_ovf);
      end
      $display("reset_abort: restart 77 -> bcd=%h", a_bcd);
   endtask

   task automatic test_wide;
      bit seen;
      int unsigned v;
      logic [19:0] exp_bcd;
      int bad;
      @(negedge clk);
      b_start = 1'b1; b_bin = 16'd65535;
      @(negedge clk);
      b_start = 1'b0;
      wait_b(25, seen);
      checks++;
      if (!seen || b_bcd !== 20'h65535 || b_ovf !== 1'b0) begin
         errors++; $display("FAIL wide_max: seen=%0b bcd=%h ovf=%0b, required 1/65535/0", seen, b_bcd, b_ovf);
      end
      $display("wide: 65535 -> bcd=%h ovf=%0b", b_bcd, b_ovf);
      bad = 0;
      for (int n = 0; n < 1000; n++) begin
         v = (n == 0) ? 0 : $urandom_range(0, 65535);
         exp_bcd = ref_bcd20(v);
         @(negedge clk);
         b_start = 1'b1; b_bin = 16'(v);
         @(negedge clk);
         b_start = 1'b0;
         wait_b(25, seen);
         checks++;
         if (!seen || b_bcd !== exp_bcd || b_ovf !== 1'b0) begin
            errors++; bad++;
            $display("FAIL wide_sweep[%0d]: in=%0d seen=%0b bcd=%h ovf=%0b, required %h/0", n, v, seen, b_bcd, b_ovf, exp_bcd);
         end
      end
      $display("wide: sweep of 1000 vectors, %0d bad", bad);
   endtask

   task automatic test_ovf;
      bit seen;
      @(negedge clk);
      c_start = 1'b1; c_bin = 8'd200;
      @(negedge clk);
      c_start = 1'b0;
      wait_c(20, seen);
      checks++;
      if (!seen || c_bcd !== 8'h00 || c_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_200: seen=%0b bcd=%h ovf=%0b, required 1/00/1", seen, c_bcd, c_ovf);
      end
      $display("ovf: 200 -> bcd=%h ovf=%0b", c_bcd, c_ovf);
      @(negedge clk);
      c_start = 1'b1; c_bin = 8'd99;
      @(negedge clk);
      c_start = 1'b0;
      wait_c(20, seen);
      checks++;
      if (!seen || c_bcd !== 8'h99 || c_ovf !== 1'b0) begin
         errors++; $display("FAIL ovf_99: seen=%0b bcd=%h ovf=%0b, required 1/99/0", seen, c_bcd, c_ovf);
      end
      $display("ovf: 99 -> bcd=%h ovf=%0b", c_bcd, c_ovf);
      @(negedge clk);
      c_start = 1'b1; c_bin = 8'd255;
      @(negedge clk);
      c_start = 1'b0;
      wait_c(20, seen);
      checks++;
      if (!seen || c_bcd !== 8'h55 || c_ovf !== 1'b1) begin
         errors++; $display("FAIL ovf_255: seen=%0b bcd=%h ovf=%0b, required 1/55/1", seen, c_bcd, c_ovf);
      end
      $display("ovf: 255 -> bcd=%h ovf=%0b", c_bcd, c_ovf);
   endtask

   initial begin
      test_reset();
      test_digit_adj();
      test_basic();
      test_back_to_back();
      test_ignored_start();
      test_reset_abort();
      test_wide();
      test_ovf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
